// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl
//   Turns the raw USB HID keycode into per-frame Tetris move commands.
//   The keycode is sampled once per video frame. Left/right use delayed
//   auto-shift followed by auto-repeat. Soft drop repeats at a fixed rate.
//   Rotate and hard drop fire once per press. Commands are registered and
//   held for a whole frame, so the frame-clocked game logic samples them
//   safely.
//
//   Optional macro KEY_ARROWS_EN: when defined, the arrow keys 0x50/0x4F/0x51/0x52
//   also map to LEFT/RIGHT/SOFT/ROT.
//
// Ports
//   Clk         in   50 MHz system clock
//   Reset_n     in   asynchronous active-low reset
//   frame_clk   in   frame strobe (~VGA_VS), asynchronous to Clk
//   keycode     in   [7:0] current HID keycode, 0x00 = no key
//   move_left   out  shift piece left this frame
//   move_right  out  shift piece right this frame
//   soft_drop   out  drop piece one row this frame
//   rotate_cw   out  rotate piece clockwise this frame
//   hard_drop   out  drop piece to floor this frame
//   frame_tick  out  one-Clk pulse per synchronized frame_clk rising edge
module tetris_input_ctrl #(
  parameter int DAS_FRAMES  = 10,
  parameter int ARR_FRAMES  = 3,
  parameter int SOFT_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       move_left,
  output logic       move_right,
  output logic       soft_drop,
  output logic       rotate_cw,
  output logic       hard_drop,
  output logic       frame_tick
);

  typedef enum logic [1:0] {IDLE, DAS_WAIT, REPEAT, HOLD} state_t;
  typedef enum logic [2:0] {A_NONE, A_LEFT, A_RIGHT, A_SOFT, A_ROT, A_HARD} act_t;

  function automatic act_t decode(input logic [7:0] kc);
    act_t a;
    case (kc)
      8'h04:   a = A_LEFT;
      8'h07:   a = A_RIGHT;
      8'h16:   a = A_SOFT;
      8'h1A:   a = A_ROT;
      8'h2C:   a = A_HARD;
`ifdef KEY_ARROWS_EN
      8'h50:   a = A_LEFT;
      8'h4F:   a = A_RIGHT;
      8'h51:   a = A_SOFT;
      8'h52:   a = A_ROT;
`endif
      default: a = A_NONE;
    endcase
    return a;
  endfunction

  // frame_clk synchronizer: fs1/fs2 resynchronize, fs3 is the edge detector.
  // The tick itself is registered, so it rises 2-3 Clk after frame_clk.
  logic fs1, fs2, fs3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1        <= 1'b0;
      fs2        <= 1'b0;
      fs3        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fs1        <= frame_clk;
      fs2        <= fs1;
      fs3        <= fs2;
      frame_tick <= fs2 & ~fs3;
    end
  end

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [7:0] prev_key;
  logic [4:0] cmd, cmd_nxt;   // {hard, rot, soft, right, left}
  logic       fire;

  act_t act;
  logic changed;

  // Comparing the raw keycode, not the decoded action: switching between
  // two codes with the same action is still a new press.
  assign act     = decode(keycode);
  assign changed = (keycode != prev_key);

  // State register; everything advances only on the frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_key <= '0;
      cmd      <= '0;
    end else if (frame_tick) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      prev_key <= keycode;
      cmd      <= cmd_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    if (changed) begin
      if (act == A_NONE) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        // A new press restarts from scratch regardless of current state.
        fire = 1'b1;
        case (act)
          A_LEFT, A_RIGHT: begin state_nxt = DAS_WAIT; cnt_nxt = 6'd1; end
          A_SOFT:          begin state_nxt = REPEAT;   cnt_nxt = 6'd1; end
          default:         begin state_nxt = HOLD;     cnt_nxt = '0;   end
        endcase
      end
    end else begin
      case (state)
        DAS_WAIT: begin
          if (cnt == 6'(DAS_FRAMES)) begin
            fire      = 1'b1;
            cnt_nxt   = 6'd1;
            state_nxt = REPEAT;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        REPEAT: begin
          if (cnt == ((act == A_SOFT) ? 6'(SOFT_FRAMES) : 6'(ARR_FRAMES))) begin
            fire    = 1'b1;
            cnt_nxt = 6'd1;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        default: ;  // IDLE and HOLD wait for a key change
      endcase
    end
  end

  // Output decode: at most one command bit, rewritten every tick.
  always_comb begin
    cmd_nxt = '0;
    if (fire) begin
      case (act)
        A_LEFT:  cmd_nxt[0] = 1'b1;
        A_RIGHT: cmd_nxt[1] = 1'b1;
        A_SOFT:  cmd_nxt[2] = 1'b1;
        A_ROT:   cmd_nxt[3] = 1'b1;
        A_HARD:  cmd_nxt[4] = 1'b1;
        default: ;
      endcase
    end
  end

  assign move_left  = cmd[0];
  assign move_right = cmd[1];
  assign soft_drop  = cmd[2];
  assign rotate_cw  = cmd[3];
  assign hard_drop  = cmd[4];

endmodule
